// File: rtl/decimate_framer_if.sv
// Output frame stream of decimate_framer: sample, valid/ready handshake and end-of-frame marker.
interface decimate_framer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_last;
    logic             m_ready;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/decimate_framer.sv
// Keeps every DECIM-th input sample, packs kept samples into FRAME_LEN frames in a
// ping-pong buffer pair, and streams completed frames out over a valid/ready bus.
module decimate_framer #(
    parameter int WIDTH     = 8,
    parameter int DECIM     = 4,
    parameter int FRAME_LEN = 64
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic signed [WIDTH-1:0] audio_in,
    input  logic                    valid_in,
    decimate_framer_if.master       stream,
    input  logic                    clear_ovf,
    output logic                    overflow,
    output logic [15:0]             drop_count
);
    localparam int            AW       = $clog2(FRAME_LEN);
    localparam logic [3:0]    DCNT_MAX = 4'(DECIM - 1);
    localparam logic [AW-1:0] IDX_MAX  = AW'(FRAME_LEN - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t           state, state_nxt;
    logic [3:0]       dcnt;
    logic [AW-1:0]    widx, ridx;
    logic             w_sel, r_sel;
    logic [1:0]       full;
    logic [WIDTH-1:0] mem [2][FRAME_LEN];

    logic kept, wr_en, drop, wr_wrap, rd_last, xfer, frame_done;

    // Write/drop decisions look at full[] before the edge, so a buffer freed this cycle is not yet writable.
    assign kept       = valid_in && (dcnt == 4'd0);
    assign wr_en      = kept && !full[w_sel];
    assign drop       = kept && full[w_sel];
    assign wr_wrap    = (widx == IDX_MAX);
    assign rd_last    = (ridx == IDX_MAX);
    assign xfer       = (state == STREAM) && stream.m_ready;
    assign frame_done = xfer && rd_last;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            dcnt <= 4'd0;
        end else if (valid_in) begin
            dcnt <= (dcnt == DCNT_MAX) ? 4'd0 : dcnt + 4'd1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            widx  <= '0;
            w_sel <= 1'b0;
        end else if (wr_en) begin
            if (wr_wrap) begin
                widx  <= '0;
                w_sel <= ~w_sel;
            end else begin
                widx <= widx + AW'(1);
            end
        end
    end

    // NOTE: the sample buffers carry no reset; full[] gates every read, so stale contents never reach the bus.
    always_ff @(posedge clk_in) begin
        if (wr_en) mem[w_sel][widx] <= audio_in;
    end

    // Writer only fills an empty buffer and reader only frees a full one, so the two never hit the same bit.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            full <= 2'b00;
        end else begin
            if (wr_en && wr_wrap) full[w_sel] <= 1'b1;
            if (frame_done)       full[r_sel] <= 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            overflow   <= 1'b0;
            drop_count <= 16'h0000;
        end else if (clear_ovf) begin
            overflow   <= 1'b0;
            drop_count <= 16'h0000;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'h0001;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state <= IDLE;
        else         state <= state_nxt;
    end

    // NOTE: combinational blocks assign every output a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (full[r_sel]) state_nxt = STREAM;
            STREAM: if (frame_done)  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            ridx  <= '0;
            r_sel <= 1'b0;
        end else if (state == IDLE) begin
            ridx <= '0;
        end else if (xfer) begin
            if (rd_last) begin
                ridx  <= '0;
                r_sel <= ~r_sel;
            end else begin
                ridx <= ridx + AW'(1);
            end
        end
    end

    // The buffer being read stays full until its last transfer, so m_data is stable under back-pressure.
    always_comb begin
        stream.m_valid = 1'b0;
        stream.m_last  = 1'b0;
        stream.m_data  = '0;
        if (state == STREAM) begin
            stream.m_valid = 1'b1;
            stream.m_last  = rd_last;
            stream.m_data  = mem[r_sel][ridx];
        end
    end
endmodule

// File: tb/tb_decimate_framer.sv
// Randomized and directed bench for decimate_framer: a frame-level reference model feeds an
// expected-output queue that a separate monitor drains against the output stream.
module tb_decimate_framer;
    localparam int WIDTH     = 8;
    localparam int DECIM     = 4;
    localparam int FRAME_LEN = 8;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [7:0]  audio_in, audio1;
    logic        valid_in, valid1, clear_ovf;
    logic        overflow, ovf1;
    logic [15:0] drop_count, dc1;
    logic        clr1 = 1'b0;

    always #5 clk_in = ~clk_in;

    decimate_framer_if #(.WIDTH(WIDTH)) bus ();
    decimate_framer_if #(.WIDTH(WIDTH)) bus1 ();

    decimate_framer #(.WIDTH(WIDTH), .DECIM(DECIM), .FRAME_LEN(FRAME_LEN)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .audio_in(audio_in), .valid_in(valid_in),
        .stream(bus), .clear_ovf(clear_ovf), .overflow(overflow), .drop_count(drop_count)
    );

    decimate_framer #(.WIDTH(WIDTH), .DECIM(1), .FRAME_LEN(FRAME_LEN)) dut1 (
        .clk_in(clk_in), .rst_in(rst_in), .audio_in(audio1), .valid_in(valid1),
        .stream(bus1), .clear_ovf(clr1), .overflow(ovf1), .drop_count(dc1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frames are lists of kept samples; a buffer is "held" from completion until
    // FRAME_LEN transfers have drained it. A kept sample finding two held frames is lost.
    typedef struct {
        logic [7:0] data;
        logic       last;
    } item_t;

    item_t       exp_q[$];
    logic [7:0]  partial[$];
    int          held, n_valid, xfer_cnt;
    int unsigned exp_drops;
    logic        exp_ovf;

    always @(negedge clk_in) begin
        item_t it;
        if (!rst_in) begin
            exp_q.delete();
            partial.delete();
            held = 0; n_valid = 0; xfer_cnt = 0; exp_drops = 0; exp_ovf = 1'b0;
        end else begin
            check("drop_count", 32'(drop_count), exp_drops);
            check("overflow", 32'(overflow), 32'(exp_ovf));
            if (valid_in) begin
                if (n_valid % DECIM == 0) begin
                    if (held == 2) begin
                        exp_ovf = 1'b1;
                        if (exp_drops < 65535) exp_drops++;
                    end else begin
                        partial.push_back(audio_in);
                        if (partial.size() == FRAME_LEN) begin
                            foreach (partial[i]) begin
                                it.data = partial[i];
                                it.last = (i == FRAME_LEN - 1);
                                exp_q.push_back(it);
                            end
                            partial.delete();
                            held++;
                        end
                    end
                end
                n_valid++;
            end
            if (clear_ovf) begin
                exp_ovf   = 1'b0;
                exp_drops = 0;
            end
            if (bus.m_valid && bus.m_ready) begin
                xfer_cnt++;
                if (xfer_cnt % FRAME_LEN == 0) held--;
            end
        end
    end

    // Monitor: compares every presented sample (stalled cycles included) against the queue head.
    logic prev_last_xfer = 1'b0;

    always @(negedge clk_in) begin
        item_t tmp;
        if (!rst_in) begin
            check("rst_m_valid", 32'(bus.m_valid), 32'd0);
            check("rst_m_last", 32'(bus.m_last), 32'd0);
            check("rst_m_data", 32'(bus.m_data), 32'd0);
            check("rst_drop_count", 32'(drop_count), 32'd0);
            prev_last_xfer = 1'b0;
        end else begin
            if (prev_last_xfer) check("gap_between_frames", 32'(bus.m_valid), 32'd0);
            prev_last_xfer = 1'b0;
            if (bus.m_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=%0h required=none", bus.m_data);
                end else begin
                    check("m_data", 32'(bus.m_data), 32'(exp_q[0].data));
                    check("m_last", 32'(bus.m_last), 32'(exp_q[0].last));
                    if (bus.m_ready) begin
                        prev_last_xfer = exp_q[0].last;
                        tmp = exp_q.pop_front();
                    end
                end
            end
        end
    end

    // DECIM=1 instance: expected values pushed at stimulus time, popped on each transfer.
    int q1[$];
    int n1_out = 0;

    always @(negedge clk_in) begin
        int tmp1;
        if (rst_in && bus1.m_valid && bus1.m_ready) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dec1_unexpected actual=%0h required=none", bus1.m_data);
            end else begin
                check("dec1_data", 32'($signed(bus1.m_data)), q1[0]);
                check("dec1_last", 32'(bus1.m_last), 32'((n1_out % FRAME_LEN) == FRAME_LEN - 1));
                n1_out++;
                tmp1 = q1.pop_front();
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send(input logic [7:0] v, input int gap);
        audio_in = v;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        repeat (gap - 1) tick();
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!bus.m_valid && n < 300) begin
            tick();
            n++;
        end
        check(name, 32'(bus.m_valid), 32'd1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        bus.m_ready = 1'b1;
        while ((exp_q.size() != 0 || bus.m_valid) && n < 400) begin
            tick();
            n++;
        end
        check(name, exp_q.size(), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int thr;
        rst_in = 1'b0; valid_in = 1'b0; audio_in = '0; clear_ovf = 1'b0;
        valid1 = 1'b0; audio1 = '0; bus.m_ready = 1'b0; bus1.m_ready = 1'b1;
        repeat (3) tick();
        rst_in = 1'b1;
        tick();

        // DECIM=1: alternating extremes must come out unmodified and every sample kept.
        for (int i = 0; i < 16; i++) begin
            audio1 = (i % 2 == 0) ? 8'h80 : 8'h7F;
            q1.push_back((i % 2 == 0) ? -128 : 127);
            valid1 = 1'b1;
            tick();
        end
        valid1 = 1'b0;
        n = 0;
        while (q1.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        check("dec1_drain", q1.size(), 32'd0);

        // One frame 0,4,...,28 with the consumer always ready.
        bus.m_ready = 1'b1;
        for (int i = 0; i < 32; i++) send(8'(i), 3);
        drain("basic_frame_drain");

        // Consumer stalls for 20 cycles after the frame appears.
        bus.m_ready = 1'b0;
        fork
            for (int i = 0; i < 32; i++) send(8'(i), 3);
            begin
                wait_valid("stall_valid_rise");
                repeat (20) tick();
                bus.m_ready = 1'b1;
            end
        join
        drain("stall_drain");

        // Both buffers fill, the third frame's samples are lost.
        bus.m_ready = 1'b0;
        for (int i = 0; i < 96; i++) send(8'(i), 1);
        check("ovf_drop_count", 32'(drop_count), 32'd8);
        check("ovf_flag", 32'(overflow), 32'd1);
        drain("ovf_drain");
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        check("clear_drop_count", 32'(drop_count), 32'd0);
        check("clear_flag", 32'(overflow), 32'd0);

        // Reset mid-frame discards the partial frame.
        bus.m_ready = 1'b1;
        for (int i = 0; i < 20; i++) send(8'(200 + i), 1);
        rst_in = 1'b0;
        repeat (2) tick();
        rst_in = 1'b1;
        for (int i = 0; i < 32; i++) send(8'(100 + i), 1);
        drain("post_reset_drain");

        // Kept sample lands in the same cycle the reader frees a buffer: it is dropped.
        bus.m_ready = 1'b0;
        for (int i = 0; i < 64; i++) send(8'(i), 1);
        wait_valid("freeing_valid");
        for (int k = 0; k < FRAME_LEN; k++) begin
            bus.m_ready = 1'b1;
            valid_in    = (k == FRAME_LEN - 1);
            audio_in    = 8'h55;
            tick();
        end
        valid_in    = 1'b0;
        bus.m_ready = 1'b0;
        check("free_collision_drop", 32'(drop_count), 32'd1);
        for (int i = 0; i < 32; i++) send(8'(8'h60 + i), 1);
        drain("free_collision_drain");

        // Randomized traffic with bursts of back-pressure and occasional clears.
        thr = 4;
        for (int c = 0; c < 1500; c++) begin
            if (c % 100 == 0) thr = int'($urandom_range(0, 8));
            valid_in    = ($urandom_range(0, 2) != 0);
            audio_in    = 8'($urandom);
            bus.m_ready = (int'($urandom_range(0, 7)) < thr);
            clear_ovf   = ($urandom_range(0, 299) == 0);
            tick();
        end
        valid_in  = 1'b0;
        clear_ovf = 1'b0;
        drain("random_drain");
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
